fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch stage feeding the decode/control_unit side of the risc_v core.
//  Owns the fetch PC and drives the instr_mem address.
//  Buffers fetched words with their PCs in a DEPTH-entry FIFO.
//  Hands them to decode over a valid/ready handshake; a redirect (taken branch/jump) flushes it.
// PARAMETERS
//  DATA_WIDTH  32   instruction / address width
//  DEPTH       4    FIFO entries; power of two, >= 2
//  RESET_PC    0    fetch PC loaded on reset; low 2 bits must be 0
// PORTS
//  CLK           in   1               clock, all state updates on rising edge
//  RST           in   1               reset, synchronous, active-high
//  IMemA         out  DATA_WIDTH      instr_mem address (= FetchPC)
//  IMemRD        in   DATA_WIDTH      instr_mem read data, combinational from IMemA
//  IMemReady     in   1               memory can serve this cycle; 0 = fetch stall
//  Redirect      in   1               flush queue and restart fetch at RedirectPC
//  RedirectPC    in   DATA_WIDTH      new fetch target; bits [1:0] ignored (forced 0)
//  DecodeReady   in   1               decode consumes head entry this cycle
//  InstrValid    out  1               head entry valid
//  Instr         out  DATA_WIDTH      head instruction
//  InstrPC       out  DATA_WIDTH      PC of head instruction
//  InstrPCPlus4  out  DATA_WIDTH      InstrPC + 4 (mod 2^DATA_WIDTH)
//  Count         out  $clog2(DEPTH)+1 entries held, 0..DEPTH
// BEHAVIOUR
//  Reset (RST=1 at edge): FetchPC<=RESET_PC, rd/wr ptr<=0, Count<=0; InstrValid=0.
//    Instr/InstrPC/InstrPCPlus4 are don't-care while InstrValid=0.
//  IMemA = FetchPC at all times (including during reset).
//  pop  = InstrValid & DecodeReady & ~Redirect.
//  push = ~RST & ~Redirect & IMemReady & ((Count<DEPTH) | pop).
//    A full queue accepts a push in the same cycle as a pop.
//  push: store {IMemRD, FetchPC} at wr ptr; FetchPC<=FetchPC+4 (wraps at 2^DATA_WIDTH).
//  No push: FetchPC holds.
//  pop: rd ptr advances. Count<=Count+push-pop. Pointers wrap modulo DEPTH.
//  Outputs are combinational from the head slot; InstrValid = (Count!=0).
//  Latency: word fetched at edge N is visible at decode after edge N (1 cycle).
//  Redirect (highest priority after RST), at the edge:
//    - ptrs<=0, Count<=0, FetchPC<={RedirectPC[31:2],2'b00}.
//    - no push and no pop that cycle, even if DecodeReady=1.
//    - InstrValid=0 for exactly one cycle; first new word valid after the next push edge.
//  Back-to-back Redirects: the last one wins; nothing is pushed in between.
//  IMemReady=0: no push, FetchPC holds; pops continue and can drain to empty.
//  Empty and DecodeReady=1: no-op; Count never underflows.
//  Full, no pop: no push, FetchPC holds; no word dropped or duplicated.
//  RST mid-operation discards all entries (same as reset above).
// TESTING
//  1 Reset release, RESET_PC=0, DecodeReady=1, mem returns addr>>2:
//    -> InstrValid rises one cycle after RST falls; InstrPC 0,4,8... consecutive;
//       Instr 0,1,2...; Count stays 1.
//  2 DecodeReady=0 for 10 cycles:
//    -> Count 1,2,3,4 then holds at 4; FetchPC holds at 0x10.
//    Then DecodeReady=1 -> InstrPC 0,4,8,0xC,0x10 with no gap or duplicate.
//  3 Full queue, DecodeReady=1 for a single cycle:
//    -> pop and push in that cycle; Count stays 4; FetchPC advances by 4.
//  4 Redirect=1 with RedirectPC=0x43 while Count=3:
//    -> next cycle Count=0, InstrValid=0, IMemA=0x40;
//       following cycle InstrPC=0x40, InstrPCPlus4=0x44.
//  5 IMemReady low for 3 cycles while DecodeReady=1:
//    -> queue drains to empty, IMemA holds;
//       on resume the next PC follows the last pushed PC + 4.
//  6 Wrap: redirect to 0xFFFFFFFC
//    -> InstrPC 0xFFFFFFFC then 0x00000000; InstrPCPlus4 of first entry = 0x0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-side bus: instruction-memory port plus the decode valid/ready handshake.
// The master modport is the fetch queue's view; the slave modport is the memory/decode view.
interface fetch_queue_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [DATA_WIDTH-1:0] IMemA;
   logic [DATA_WIDTH-1:0] IMemRD;
   logic                  IMemReady;
   logic                  Redirect;
   logic [DATA_WIDTH-1:0] RedirectPC;
   logic                  DecodeReady;
   logic                  InstrValid;
   logic [DATA_WIDTH-1:0] Instr;
   logic [DATA_WIDTH-1:0] InstrPC;
   logic [DATA_WIDTH-1:0] InstrPCPlus4;
   logic [CW-1:0]         Count;

   modport master (
      output IMemA, InstrValid, Instr, InstrPC, InstrPCPlus4, Count,
      input  IMemRD, IMemReady, Redirect, RedirectPC, DecodeReady
   );

   modport slave (
      input  IMemA, InstrValid, Instr, InstrPC, InstrPCPlus4, Count,
      output IMemRD, IMemReady, Redirect, RedirectPC, DecodeReady
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, buffers {instr, pc} pairs in a small FIFO
// and presents the head entry to decode; a redirect flushes the queue and restarts fetch.
module fetch_queue #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic          CLK,
   input  logic          RST,
   fetch_queue_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [DATA_WIDTH-1:0] instr_q [DEPTH];
   logic [DATA_WIDTH-1:0] instr_d [DEPTH];
   logic [DATA_WIDTH-1:0] pc_q    [DEPTH];
   logic [DATA_WIDTH-1:0] pc_d    [DEPTH];
   logic                  pop, push;

   // A full queue may still push when the head leaves in the same cycle.
   assign pop  = (count_q != '0) && bus.DecodeReady && !bus.Redirect;
   assign push = !RST && !bus.Redirect && bus.IMemReady &&
                 ((count_q < CW'(DEPTH)) || pop);

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      fetch_pc_d = fetch_pc_q;
      if (bus.Redirect) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = {bus.RedirectPC[DATA_WIDTH-1:2], 2'b00};
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      if (push) begin
         instr_d[wr_ptr_q] = bus.IMemRD;
         pc_d[wr_ptr_q]    = fetch_pc_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         fetch_pc_q <= RESET_PC;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   // Payload storage needs no reset; entries are only observed while counted valid.
   always_ff @(posedge CLK) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
   end

   assign bus.IMemA        = fetch_pc_q;
   assign bus.InstrValid   = (count_q != '0);
   assign bus.Instr        = instr_q[rd_ptr_q];
   assign bus.InstrPC      = pc_q[rd_ptr_q];
   assign bus.InstrPCPlus4 = pc_q[rd_ptr_q] + DATA_WIDTH'(4);
   assign bus.Count        = count_q;
endmodule
